// File: rtl/ultrasonic_ranger4_pkg.sv
// Shared definitions for the four-sensor ultrasonic ranger: sensor indices,
// the "no echo / far" distance code and FSM state encodings.
package ultrasonic_ranger4_pkg;

    localparam logic [1:0]  SENS_F   = 2'd0;
    localparam logic [1:0]  SENS_B   = 2'd1;
    localparam logic [1:0]  SENS_L   = 2'd2;
    localparam logic [1:0]  SENS_R   = 2'd3;

    localparam logic [12:0] DIST_FAR = 13'h1FFF;

    typedef enum logic [1:0] {
        ST_TRIG      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger4_echo_sync_edge.sv
// Two-flop synchroniser for the raw echo lines followed by registered
// rise/fall pulses, one bit per sensor.
module echo_sync_edge #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_echo,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_prev;
    logic [W-1:0] r_rise;
    logic [W-1:0] r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_s1   <= i_echo;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_rise <= r_s2 & ~r_prev;
            r_fall <= ~r_s2 & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/ultrasonic_ranger4.sv
// Round-robin driver for four HC-SR04-style sensors: one trigger per slot,
// echo width measured in millimetres and latched per sensor.
module ultrasonic_ranger4
    import ultrasonic_ranger4_pkg::*;
#(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          TRIG_CYC    = CLK_HZ / 100_000,
    parameter int          CYC_PER_MM  = 292,
    parameter int          TIMEOUT_CYC = CLK_HZ / 100 * 3,
    parameter int          SLOT_CYC    = CLK_HZ / 20,
    parameter logic [12:0] MAX_MM      = 13'd8190
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_echo,
    output logic [3:0]  o_trig,
    output logic [12:0] o_distance_data_f,
    output logic [12:0] o_distance_data_b,
    output logic [12:0] o_distance_data_l,
    output logic [12:0] o_distance_data_r,
    output logic [3:0]  o_dist_vld
);

    localparam int TRIG_W = $clog2(TRIG_CYC + 1);
    localparam int PRE_W  = $clog2(CYC_PER_MM + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    // Wide enough for the longest slot, when a late echo stretches it past SLOT_CYC.
    localparam int SLOT_W = $clog2(SLOT_CYC + TRIG_CYC + 2 * TIMEOUT_CYC + 4);

    logic [3:0]        w_rise_v;
    logic [3:0]        w_fall_v;
    logic              w_rise;
    logic              w_fall;
    logic              w_tmo;
    logic              w_wrap;
    logic [12:0]       w_mm_inc;
    logic [12:0]       w_mm_next;

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [TRIG_W-1:0] r_trig_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [PRE_W-1:0]  r_presc;
    logic [12:0]       r_mm_cnt;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [3:0]        r_trig;
    logic [3:0][12:0]  r_dist;
    logic [3:0]        r_vld;

    echo_sync_edge #(.W(4)) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_echo (i_echo),
        .o_rise (w_rise_v),
        .o_fall (w_fall_v)
    );

    assign w_rise    = w_rise_v[r_sel];
    assign w_fall    = w_fall_v[r_sel];
    assign w_tmo     = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign w_wrap    = (r_presc == PRE_W'(CYC_PER_MM - 1));
    assign w_mm_inc  = (r_mm_cnt >= MAX_MM) ? MAX_MM : r_mm_cnt + 13'd1;
    // Counting the current cycle lets a fall on a wrap report the full width.
    assign w_mm_next = w_wrap ? w_mm_inc : r_mm_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_TRIG;
            r_sel      <= SENS_F;
            r_trig_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_presc    <= '0;
            r_mm_cnt   <= '0;
            r_slot_cnt <= '0;
            r_trig     <= '0;
            r_dist     <= {4{DIST_FAR}};
            r_vld      <= '0;
        end else begin
            r_vld      <= '0;
            r_slot_cnt <= r_slot_cnt + 1'b1;
            case (r_state)
                ST_TRIG: begin
                    if (r_trig_cnt == TRIG_W'(TRIG_CYC)) begin
                        r_trig    <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_WAIT_RISE;
                    end else begin
                        r_trig     <= sel_onehot(r_sel);
                        r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        r_presc   <= '0;
                        r_mm_cnt  <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_MEASURE;
                    end else if (w_tmo) begin
                        r_dist[r_sel] <= DIST_FAR;
                        r_vld         <= sel_onehot(r_sel);
                        r_state       <= ST_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_fall) begin
                        r_dist[r_sel] <= w_mm_next;
                        r_vld         <= sel_onehot(r_sel);
                        r_state       <= ST_HOLD;
                    end else if (w_tmo) begin
                        r_dist[r_sel] <= DIST_FAR;
                        r_vld         <= sel_onehot(r_sel);
                        r_state       <= ST_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        r_presc   <= w_wrap ? '0 : r_presc + 1'b1;
                        r_mm_cnt  <= w_mm_next;
                    end
                end
                ST_HOLD: begin
                    if (r_slot_cnt >= SLOT_W'(SLOT_CYC - 1)) begin
                        r_sel      <= r_sel + 2'd1;
                        r_trig_cnt <= '0;
                        r_slot_cnt <= '0;
                        r_state    <= ST_TRIG;
                    end
                end
                default: r_state <= ST_TRIG;
            endcase
        end
    end

    assign o_trig            = r_trig;
    assign o_distance_data_f = r_dist[SENS_F];
    assign o_distance_data_b = r_dist[SENS_B];
    assign o_distance_data_l = r_dist[SENS_L];
    assign o_distance_data_r = r_dist[SENS_R];
    assign o_dist_vld        = r_vld;

endmodule

// File: tb/tb_ultrasonic_ranger4.sv
// Bench for ultrasonic_ranger4: event-level slot model (start, hold, result
// per slot) checked every cycle, plus literal spot checks on key cycles.
module tb_ultrasonic_ranger4;

    localparam int          TRIG = 5;
    localparam int          TMO  = 2000;
    localparam int          SLOT = 3000;
    localparam int          NS   = 16;
    localparam logic [12:0] FAR  = 13'h1FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  echo1 = '0, echo2 = '0;
    logic [3:0]  trig1, trig2, vld1, vld2;
    logic [12:0] f1, b1, l1, r1, f2, b2, l2, r2;

    always #5 clk = ~clk;

    ultrasonic_ranger4 #(.CYC_PER_MM(10), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO), .SLOT_CYC(SLOT)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_echo(echo1), .o_trig(trig1),
        .o_distance_data_f(f1), .o_distance_data_b(b1),
        .o_distance_data_l(l1), .o_distance_data_r(r1), .o_dist_vld(vld1));

    ultrasonic_ranger4 #(.CYC_PER_MM(1), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO), .SLOT_CYC(SLOT),
                         .MAX_MM(13'd1000)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_echo(echo2), .o_trig(trig2),
        .o_distance_data_f(f2), .o_distance_data_b(b2),
        .o_distance_data_l(l2), .o_distance_data_r(r2), .o_dist_vld(vld2));

    // Stimulus per slot: kind 0 = no echo, 1 = pulse (delay after trig fall, width), 2 = stale high
    int kind [2][NS];
    int dly  [2][NS];
    int wid  [2][NS];
    int S    [2][NS+1];
    int H    [2][NS];
    int RES  [2][NS];
    int EA   [2][NS];
    int EE   [2][NS];
    int cpm  [2] = '{10, 1};
    int mxm  [2] = '{8190, 1000};
    int nsl;

    int   cyc = 0;
    logic rst_q = 1'b1;
    bit   chk_en = 1'b0;
    int   n_chk = 0, n_pass = 0;

    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    always @(posedge clk) assert ($onehot0(trig1) && $onehot0(trig2)) else $error("trig not one-hot");

    task automatic clear_stim(input int n);
        nsl = n;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NS; i++) begin
                kind[d][i] = 0; dly[d][i] = 0; wid[d][i] = 0;
            end
    endtask

    task automatic set_stim(input int d, input int i, input int k, input int dl, input int w);
        kind[d][i] = k; dly[d][i] = dl; wid[d][i] = w;
    endtask

    // Slot timeline in clock edges after reset: slot starts at s, trig high s+1..s+TRIG,
    // echo seen 3 edges after it changes, slot ends at max(s+SLOT, hold+1).
    task automatic build(input int d);
        int s, ew, em;
        s = 0;
        for (int i = 0; i < nsl; i++) begin
            S[d][i] = s;
            ew = s + TRIG + 1;
            EA[d][i] = 0; EE[d][i] = 0;
            H[d][i] = ew + TMO; RES[d][i] = FAR;
            if (kind[d][i] == 1) begin
                EA[d][i] = ew + dly[d][i];
                EE[d][i] = EA[d][i] + wid[d][i];
                em = EA[d][i] + 3;
                if (wid[d][i] <= TMO) begin
                    H[d][i]   = em + wid[d][i];
                    RES[d][i] = (wid[d][i] / cpm[d] > mxm[d]) ? mxm[d] : wid[d][i] / cpm[d];
                end else begin
                    H[d][i] = em + TMO;
                end
            end else if (kind[d][i] == 2) begin
                EA[d][i] = s + 1;
                EE[d][i] = ew + TMO + 10;
            end
            s = (s + SLOT > H[d][i] + 1) ? s + SLOT : H[d][i] + 1;
        end
        S[d][nsl] = s;
    endtask

    task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d + 1, cyc, act, exp);
    endtask

    task automatic at(input int n);
        int g;
        g = 0;
        while (cyc != n && g < 60000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            n_chk++;
            $display("FAIL wait_cyc target=%0d reached=%0d", n, cyc);
        end
    endtask

    // Echo driver: value for the upcoming edge cyc+1
    initial begin : drv
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                e = '0;
                if (!rst)
                    for (int i = 0; i < nsl; i++)
                        if (cyc + 1 >= EA[d][i] && cyc + 1 < EE[d][i]) e[i % 4] = 1'b1;
                if (d == 0) echo1 = e; else echo2 = e;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [3:0]  et, ev, at_, av;
        logic [12:0] ed [4];
        logic [12:0] ad [4];
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                at_ = d ? trig2 : trig1;
                av  = d ? vld2 : vld1;
                ad[0] = d ? f2 : f1; ad[1] = d ? b2 : b1;
                ad[2] = d ? l2 : l1; ad[3] = d ? r2 : r1;
                et = '0; ev = '0;
                for (int s = 0; s < 4; s++) ed[s] = FAR;
                if (rst_q || cyc < S[d][nsl]) begin
                    if (!rst_q)
                        for (int i = 0; i < nsl; i++) begin
                            if (cyc > S[d][i] && cyc <= S[d][i] + TRIG) et[i % 4] = 1'b1;
                            if (cyc == H[d][i]) ev[i % 4] = 1'b1;
                            if (cyc >= H[d][i]) ed[i % 4] = RES[d][i][12:0];
                        end
                    chk("trig", d, {12'd0, at_}, {12'd0, et});
                    chk("dist_vld", d, {12'd0, av}, {12'd0, ev});
                    for (int s = 0; s < 4; s++) chk("distance", d, {3'd0, ad[s]}, {3'd0, ed[s]});
                end
            end
        end
    end

    initial begin
        clear_stim(14);
        set_stim(0, 4, 1, 20, 1000);    // front 1000 cycles -> 100 mm
        set_stim(0, 6, 2, 0, 0);        // left stale high
        set_stim(0, 7, 1, 20, 2000);    // right fall coincides with timeout -> 200
        set_stim(0, 8, 1, 20, 2001);    // front one cycle past timeout -> far
        set_stim(0, 9, 1, 1900, 2100);  // late rise + timeout stretches the slot
        set_stim(0, 10, 1, 20, 25);
        set_stim(0, 11, 1, 20, 9);
        set_stim(0, 13, 1, 20, 1000);   // interrupted by reset
        set_stim(1, 1, 1, 20, 1500);    // saturates at 1000
        set_stim(1, 2, 1, 20, 999);
        set_stim(1, 3, 1, 20, 1000);
        build(0);
        build(1);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        at(3);     chk("trig_first", 0, {12'd0, trig1}, 16'h0001);
        at(2006);  chk("vld_f_noecho", 0, {12'd0, vld1}, 16'h0001);
                   chk("f_noecho", 0, {3'd0, f1}, {3'd0, FAR});
        at(3001);  chk("trig_b", 0, {12'd0, trig1}, 16'h0002);
        at(4529);  chk("b_sat", 1, {3'd0, b2}, 16'd1000);
        at(6001);  chk("trig_l", 0, {12'd0, trig1}, 16'h0004);
        at(7028);  chk("l_999", 1, {3'd0, l2}, 16'd999);
        at(9001);  chk("trig_r", 0, {12'd0, trig1}, 16'h0008);
        at(12001); chk("trig_wrap", 0, {12'd0, trig1}, 16'h0001);
        at(13029); chk("f_100", 0, {3'd0, f1}, 16'd100);
                   chk("vld_f", 0, {12'd0, vld1}, 16'h0001);
                   chk("b_held", 0, {3'd0, b1}, {3'd0, FAR});
        at(13030); chk("vld_once", 0, {12'd0, vld1}, 16'h0000);
        at(20006); chk("l_stale", 0, {3'd0, l1}, {3'd0, FAR});
                   chk("vld_l", 0, {12'd0, vld1}, 16'h0004);
        at(23029); chk("r_200", 0, {3'd0, r1}, 16'd200);
        at(26029); chk("f_tmo", 0, {3'd0, f1}, {3'd0, FAR});
        at(30001); chk("slot_stretch", 0, {12'd0, trig1}, 16'h0000);
        at(30911); chk("trig_after_stretch", 0, {12'd0, trig1}, 16'h0004);
        at(30964); chk("l_2", 0, {3'd0, l1}, 16'd2);
        at(40038); chk("r_before_rst", 0, {3'd0, r1}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_trig", 0, {12'd0, trig1}, 16'h0000);
        chk("rst_r", 0, {3'd0, r1}, {3'd0, FAR});
        chk("rst_l", 0, {3'd0, l1}, {3'd0, FAR});

        clear_stim(3);
        set_stim(0, 0, 1, 20, 300);
        build(0);
        build(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        at(3);    chk("restart_sel0", 0, {12'd0, trig1}, 16'h0001);
        at(329);  chk("f_30", 0, {3'd0, f1}, 16'd30);
        at(6003); chk("trig_l2", 0, {12'd0, trig1}, 16'h0004);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_trig", 0, {12'd0, trig1}, 16'h0000);
        chk("rst_f", 0, {3'd0, f1}, {3'd0, FAR});
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
